// File: rtl/ndma_pkg.sv
// ndma_pkg: shared constants and types for the NanoDMA configuration block.
//   - register word indices (cfg_addr_i[4:2])
//   - CTRL / STATUS bit positions
//   - ID register default value
//   - busy/idle state type and configuration bundle
package ndma_pkg;

    localparam int unsigned NDMA_MAX_TX     = 256;
    localparam int unsigned NDMA_LEN_W      = $clog2(NDMA_MAX_TX) + 1;
    localparam logic [31:0] NDMA_ID_DEFAULT = 32'h4E44_4D41;

    // Word indices; byte offset = index * 4.
    localparam logic [2:0] REG_SRC_ADDR = 3'd0;  // 0x00
    localparam logic [2:0] REG_DST_ADDR = 3'd1;  // 0x04
    localparam logic [2:0] REG_LENGTH   = 3'd2;  // 0x08
    localparam logic [2:0] REG_CTRL     = 3'd3;  // 0x0C
    localparam logic [2:0] REG_STATUS   = 3'd4;  // 0x10
    localparam logic [2:0] REG_ID       = 3'd5;  // 0x14

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_ABORT_BIT  = 2;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ndma_state_e;

    typedef struct packed {
        logic [31:0]           src;
        logic [31:0]           dst;
        logic [NDMA_LEN_W-1:0] len;
    } ndma_cfg_t;

endpackage

// File: rtl/ndma_cfg_regs.sv
// ndma_cfg_regs: OBI subordinate register file for the NanoDMA engine.
// Holds SRC/DST/LENGTH, issues start/abort pulses, tracks BUSY/DONE/ERR
// and drives the transfer-done interrupt.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   cfg_req_i/we_i/be_i/addr_i/wdata_i -> cfg_gnt_o, cfg_rvalid_o,
//     cfg_rdata_o, cfg_err_o            : OBI config port, 1-cycle response
//   src_addr_o, dst_addr_o, len_o      : transfer parameters to the engine
//   start_o, abort_o                   : one-cycle command pulses
//   done_i                             : one-cycle completion from engine
//   tx_done_irq_o                      : DONE & IRQ_EN level interrupt
//
// Build option: NDMA_CFG_BE_EN -- when defined, SRC/DST/LENGTH writes honour
// cfg_be_i per byte and CTRL/STATUS writes act only with cfg_be_i[0].
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no transfer running, START accepted if valid
// ST_BUSY | engine running, config locked, waits done/abort
module ndma_cfg_regs
    import ndma_pkg::*;
#(
    parameter int unsigned MaxTxSize = NDMA_MAX_TX,
    parameter logic [31:0] IdValue   = NDMA_ID_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_req_i,
    input  logic                         cfg_we_i,
    input  logic [3:0]                   cfg_be_i,
    input  logic [31:0]                  cfg_addr_i,
    input  logic [31:0]                  cfg_wdata_i,
    output logic                         cfg_gnt_o,
    output logic                         cfg_rvalid_o,
    output logic [31:0]                  cfg_rdata_o,
    output logic                         cfg_err_o,
    output logic [31:0]                  src_addr_o,
    output logic [31:0]                  dst_addr_o,
    output logic [$clog2(MaxTxSize):0]   len_o,
    output logic                         start_o,
    output logic                         abort_o,
    input  logic                         done_i,
    output logic                         tx_done_irq_o
);

    localparam int unsigned LenW = $clog2(MaxTxSize) + 1;

    ndma_state_e state_q, state_d;
    ndma_cfg_t   cfg_q, cfg_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;

    logic [2:0]  reg_idx;
    logic [31:0] wmask;
    logic        ctrl_be;
    logic        wr, rd, busy, len_ok;
    logic        ctrl_start, ctrl_abort;
    logic        done_set, done_clr, err_set, err_clr;

`ifdef NDMA_CFG_BE_EN
    assign wmask   = {{8{cfg_be_i[3]}}, {8{cfg_be_i[2]}}, {8{cfg_be_i[1]}}, {8{cfg_be_i[0]}}};
    assign ctrl_be = cfg_be_i[0];
    logic unused_bits;
    assign unused_bits = ^{cfg_addr_i[31:5], cfg_addr_i[1:0]};
`else
    assign wmask   = '1;
    assign ctrl_be = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{cfg_addr_i[31:5], cfg_addr_i[1:0], cfg_be_i};
`endif

    assign reg_idx = cfg_addr_i[4:2];
    assign wr      = cfg_req_i & cfg_we_i;
    assign rd      = cfg_req_i & ~cfg_we_i;
    assign busy    = (state_q == ST_BUSY);
    assign len_ok  = (cfg_q.len != '0) && (cfg_q.len <= NDMA_LEN_W'(MaxTxSize));

    always_comb begin
        cfg_d      = cfg_q;
        state_d    = state_q;
        irq_en_d   = irq_en_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        rvalid_d   = cfg_req_i;
        rdata_d    = '0;
        rerr_d     = 1'b0;
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        done_set   = 1'b0;
        done_clr   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;

        if (cfg_req_i) begin
            case (reg_idx)
                REG_SRC_ADDR: begin
                    if (rd) rdata_d = cfg_q.src;
                    else if (busy) rerr_d = 1'b1;
                    else cfg_d.src = (cfg_q.src & ~wmask) | (cfg_wdata_i & wmask);
                end
                REG_DST_ADDR: begin
                    if (rd) rdata_d = cfg_q.dst;
                    else if (busy) rerr_d = 1'b1;
                    else cfg_d.dst = (cfg_q.dst & ~wmask) | (cfg_wdata_i & wmask);
                end
                REG_LENGTH: begin
                    if (rd) rdata_d = 32'(cfg_q.len);
                    else if (busy) rerr_d = 1'b1;
                    else cfg_d.len = (cfg_q.len & ~wmask[NDMA_LEN_W-1:0])
                                   | (cfg_wdata_i[NDMA_LEN_W-1:0] & wmask[NDMA_LEN_W-1:0]);
                end
                REG_CTRL: begin
                    if (rd) rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                    else if (ctrl_be) begin
                        irq_en_d   = cfg_wdata_i[CTRL_IRQ_EN_BIT];
                        ctrl_start = cfg_wdata_i[CTRL_START_BIT];
                        ctrl_abort = cfg_wdata_i[CTRL_ABORT_BIT];
                    end
                end
                REG_STATUS: begin
                    if (rd) begin
                        rdata_d[STATUS_BUSY_BIT] = busy;
                        rdata_d[STATUS_DONE_BIT] = done_q;
                        rdata_d[STATUS_ERR_BIT]  = err_q;
                    end else if (ctrl_be) begin
                        done_clr = cfg_wdata_i[STATUS_DONE_BIT];
                        err_clr  = cfg_wdata_i[STATUS_ERR_BIT];
                    end
                end
                REG_ID: begin
                    if (rd) rdata_d = IdValue;
                end
                default: rerr_d = 1'b1;
            endcase
        end

        // ABORT in the same write suppresses START entirely.
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start && !ctrl_abort) begin
                    if (len_ok) begin
                        start_d = 1'b1;
                        state_d = ST_BUSY;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (ctrl_start && !ctrl_abort) err_set = 1'b1;
                if (done_i) begin
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end else if (ctrl_abort) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Hardware set takes priority over a same-cycle W1C.
        done_d = done_set | (done_q & ~done_clr);
        err_d  = err_set  | (err_q  & ~err_clr);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cfg_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    assign cfg_gnt_o     = cfg_req_i;
    assign cfg_rvalid_o  = rvalid_q;
    assign cfg_rdata_o   = rdata_q;
    assign cfg_err_o     = rerr_q;
    assign src_addr_o    = cfg_q.src;
    assign dst_addr_o    = cfg_q.dst;
    assign len_o         = LenW'(cfg_q.len);
    assign start_o       = start_q;
    assign abort_o       = abort_q;
    assign tx_done_irq_o = done_q & irq_en_q;

endmodule

// File: doc/ndma_cfg_regs.md
# ndma_cfg_regs

Memory-mapped configuration and status register file for the NanoDMA engine, acting as the OBI subordinate (responder) that terminates the engine's `cfg_*` port. It accepts single-word register reads and writes from a system OBI manager, holds the source address, destination address and transfer length, and issues start/abort pulses to the transfer engine. It tracks busy/done/error status and drives the transfer-done interrupt.

## Interface
- `MaxTxSize`, 256: maximal transfer length in words; LENGTH is `$clog2(MaxTxSize)+1` bits wide.
- `IdValue`, 32'h4E44_4D41: value returned by the ID register.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, **synchronous, active-high**.
- `cfg_req_i` in 1: OBI request.
- `cfg_we_i` in 1: write enable.
- `cfg_be_i` in 4: byte enables.
- `cfg_addr_i` in 32: byte address; only `[4:2]` decoded, `[1:0]` ignored.
- `cfg_wdata_i` in 32: write data.
- `cfg_gnt_o` out 1: grant.
- `cfg_rvalid_o` out 1: response valid.
- `cfg_rdata_o` out 32: read data.
- `cfg_err_o` out 1: response error, qualified by rvalid.
- `src_addr_o` out 32: source address to the engine.
- `dst_addr_o` out 32: destination address to the engine.
- `len_o` out `$clog2(MaxTxSize)+1`: transfer length in words.
- `start_o` out 1: one-cycle start pulse.
- `abort_o` out 1: one-cycle abort pulse.
- `done_i` in 1: one-cycle completion pulse from the engine.
- `tx_done_irq_o` out 1: level interrupt.

## Operation
- Register map, word offsets:
  - 0x00 SRC_ADDR RW.
  - 0x04 DST_ADDR RW.
  - 0x08 LENGTH RW.
  - 0x0C CTRL: bit0 START (write-1, reads 0), bit1 IRQ_EN (RW), bit2 ABORT (write-1, reads 0).
  - 0x10 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C).
  - 0x14 ID RO.
- Unmapped offsets (0x18, 0x1C) read 0, ignore writes, and respond with `cfg_err_o`=1.
- Internal `busy_q` states:
  - IDLE→BUSY on an accepted START.
  - BUSY→IDLE on `done_i` (also sets DONE) or on ABORT (does not set DONE).
- Start validation on START write in IDLE:
  - If LENGTH==0 or LENGTH>MaxTxSize: no `start_o`, set ERR, stay IDLE.
  - Otherwise `start_o` pulses and BUSY is set.
- Writes while BUSY:
  - Writes to SRC/DST/LENGTH are ignored and respond with `cfg_err_o`=1.
  - START while BUSY is ignored and sets ERR, with `cfg_err_o`=0.
  - ABORT in IDLE is a no-op.
- Same-cycle START and ABORT in one CTRL write: ABORT wins, no `start_o`.
- Simultaneous hardware set and W1C of DONE or ERR: set wins.
- `tx_done_irq_o` = DONE & IRQ_EN, combinational from registered state.
- `done_i` while IDLE: ignored; DONE is not set.
- Reset mid-transfer clears all state; no `abort_o` is emitted.

## Timing
- `cfg_gnt_o` = `cfg_req_i`, combinational; every request is granted the same cycle, with no backpressure.
- Response: `cfg_rvalid_o` is high exactly one cycle after each grant.
- `cfg_rdata_o` and `cfg_err_o` are registered. Both are 0 whenever rvalid is low; rdata is 0 on write responses.
- Read data reflects state before any same-cycle hardware update.
- Register write effects are visible on outputs the cycle after grant.
- `start_o`/`abort_o` pulse in the cycle after the granted CTRL write, concurrent with its rvalid. BUSY reads 1 from that cycle.
- `done_i` at cycle t:
  - BUSY=0 and DONE=1 at t+1.
  - `tx_done_irq_o` rises at t+1 if IRQ_EN.
- Reset values: all registers 0; `cfg_rvalid_o`, `cfg_rdata_o`, `cfg_err_o`, `start_o`, `abort_o`, `tx_done_irq_o` all 0. `len_o`, `src_addr_o`, `dst_addr_o` are 0.

## Configuration
- `NDMA_CFG_BE_EN`:
  - Defined: writes to SRC_ADDR, DST_ADDR and LENGTH honour `cfg_be_i` per byte; CTRL/STATUS act only if `cfg_be_i[0]`.
  - Undefined: `cfg_be_i` is ignored and every write is full-word.

## Structure
- Package `ndma_pkg`:
  - Register offset constants.
  - CTRL/STATUS bit index constants.
  - ID default constant.
  - A `ndma_cfg_t` struct bundling src, dst, len.
- Flat single module; no sub-module is warranted.

## Test plan
- Write SRC=0x1000, DST=0x2000, LEN=16, then CTRL=0x3 → one `start_o` pulse, `len_o`=16, STATUS reads 0x1.
- Pulse `done_i` → STATUS reads 0x2 and `tx_done_irq_o`=1; write STATUS=0x2 → irq drops next cycle.
- LEN=0, then START → no `start_o`, STATUS=0x4. Repeat with LEN=MaxTxSize+1 → same result. With LEN=MaxTxSize → starts.
- While BUSY:
  - Write SRC → `cfg_err_o`=1 and SRC unchanged.
  - CTRL=0x4 → `abort_o` pulse, BUSY=0, DONE=0.
- Read 0x14 → 0x4E444D41. Read 0x18 → rdata 0 with `cfg_err_o`=1. Back-to-back reads every cycle → rvalid every cycle.
- Same-cycle `done_i` and W1C of DONE → DONE remains 1. Assert `rst_i` while BUSY → all outputs 0 next cycle.
